// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   Single-outstanding APB requester. One command taken on a valid/ready port
//   is run as a SETUP -> ACCESS transfer. The bridge waits for pready, or gives
//   up after TIMEOUT_CYCLES ACCESS cycles. It then holds the read data and the
//   status on a valid/ready response port until the consumer takes them.
//
// Parameters
//   ADDR_W          width of cmd_addr / paddr
//   DATA_W          width of cmd_wdata / pwdata / prdata / rsp_rdata
//   TIMEOUT_CYCLES  ACCESS cycles without pready before abort (0 = never)
//
// Ports
//   clk, reset                       clock; synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write/cmd_addr/cmd_wdata     command payload
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata/rsp_err                read data (0 for writes and on error) and
//                                    timeout flag
//   busy                             high in every state except IDLE
//   psel/penable/pwrite/paddr/pwdata APB requester outputs (all registered)
//   prdata/pready                    APB completer inputs
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // The counter must be able to hold TIMEOUT_CYCLES. A disabled timeout still
  // gets a 1-bit counter so that the declarations stay legal.
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_hit;

  // An abort needs pready low: if pready arrives in the last allowed cycle,
  // the transfer completes normally.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !pready && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so the order of statements in this block cannot change behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (cmd_valid)               state_d = S_SETUP;
      S_SETUP:                               state_d = S_ACCESS;
      S_ACCESS: if (pready || timeout_hit)   state_d = S_RESP;
      S_RESP:   if (rsp_ready)               state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable is given its hold value before the case statement;
  // a path that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Write data is captured for reads too; the completer ignores it.
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      S_ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge. dut_a uses the default 16-cycle
//   timeout; dut_b uses a 4-cycle timeout for the pready/timeout collision.
//   Inputs change and outputs are sampled on the falling edge of clk.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a signals
  logic        reset, cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready;

  // dut_b signals
  logic        b_reset, b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [31:0] b_cmd_addr, b_cmd_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [31:0] b_rsp_rdata;
  logic        b_psel, b_penable, b_pwrite;
  logic [31:0] b_paddr, b_pwdata, b_prdata;
  logic        b_pready;

  int errors = 0;
  int checks = 0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .reset(b_reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy),
    .psel(b_psel), .penable(b_penable), .pwrite(b_pwrite), .paddr(b_paddr),
    .pwdata(b_pwdata), .prdata(b_prdata), .pready(b_pready)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a command for one cycle on dut_a; returns in the SETUP cycle.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b1; prdata = '0; pready = 1'b0;
    b_reset = 1'b1; b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = '0;
    b_cmd_wdata = '0; b_rsp_ready = 1'b1; b_prdata = '0; b_pready = 1'b0;
    step(); step();

    // ---- reset state ----
    check("rst_psel",      32'(psel), 0);
    check("rst_penable",   32'(penable), 0);
    check("rst_pwrite",    32'(pwrite), 0);
    check("rst_paddr",     paddr, 0);
    check("rst_pwdata",    pwdata, 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_err",   32'(rsp_err), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    reset = 1'b0; b_reset = 1'b0;
    step();

    // ---- 1: write, zero wait states ----
    pready = 1'b1;
    issue(1'b1, 32'h10, 32'hDEADBEEF);
    check("t1_setup_psel",    32'(psel), 1);
    check("t1_setup_penable", 32'(penable), 0);
    check("t1_setup_pwrite",  32'(pwrite), 1);
    check("t1_setup_paddr",   paddr, 32'h10);
    check("t1_setup_pwdata",  pwdata, 32'hDEADBEEF);
    check("t1_cmd_ready",     32'(cmd_ready), 0);
    check("t1_busy",          32'(busy), 1);
    step();
    check("t1_acc_psel",      32'(psel), 1);
    check("t1_acc_penable",   32'(penable), 1);
    check("t1_acc_paddr",     paddr, 32'h10);
    check("t1_acc_pwdata",    pwdata, 32'hDEADBEEF);
    check("t1_acc_rsp_valid", 32'(rsp_valid), 0);
    step();
    check("t1_rsp_valid",     32'(rsp_valid), 1);
    check("t1_rsp_rdata",     rsp_rdata, 0);
    check("t1_rsp_err",       32'(rsp_err), 0);
    check("t1_rsp_psel",      32'(psel), 0);
    check("t1_rsp_penable",   32'(penable), 0);
    pready = 1'b0;
    step();
    check("t1_done_rsp_valid", 32'(rsp_valid), 0);
    check("t1_done_cmd_ready", 32'(cmd_ready), 1);

    // ---- 2: read with three wait states ----
    prdata = 32'hFFFF0000;
    issue(1'b0, 32'h14, 32'h0);
    check("t2_setup_penable", 32'(penable), 0);
    check("t2_setup_pwrite",  32'(pwrite), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t2_acc%0d_penable", i), 32'(penable), 1);
      if (i == 3) begin
        pready = 1'b1;
        prdata = 32'h0000000F;
      end
    end
    step();
    check("t2_penable_drop", 32'(penable), 0);
    check("t2_rsp_valid",    32'(rsp_valid), 1);
    check("t2_rsp_rdata",    rsp_rdata, 32'h0000000F);
    check("t2_rsp_err",      32'(rsp_err), 0);
    pready = 1'b0;
    step();

    // ---- 3: timeout after 16 ACCESS cycles ----
    prdata = 32'hFFFFFFFF;
    issue(1'b0, 32'h18, 32'h0);
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("t3_acc%0d_psel_penable", i), {30'b0, psel, penable}, 3);
    end
    step();
    check("t3_psel",      32'(psel), 0);
    check("t3_penable",   32'(penable), 0);
    check("t3_rsp_valid", 32'(rsp_valid), 1);
    check("t3_rsp_err",   32'(rsp_err), 1);
    check("t3_rsp_rdata", rsp_rdata, 0);
    step();
    check("t3_err_clear", 32'(rsp_err), 0);
    check("t3_idle",      32'(cmd_ready), 1);

    // ---- 4: response backpressure ----
    rsp_ready = 1'b0;
    pready    = 1'b1;
    prdata    = 32'hA5A5A5A5;
    issue(1'b0, 32'h1C, 32'h0);
    step();
    step();
    check("t4_rsp_valid", 32'(rsp_valid), 1);
    check("t4_rsp_rdata", rsp_rdata, 32'hA5A5A5A5);
    pready    = 1'b0;
    prdata    = 32'h0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h20;
    cmd_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t4_hold%0d_valid", i), 32'(rsp_valid), 1);
      check($sformatf("t4_hold%0d_rdata", i), rsp_rdata, 32'hA5A5A5A5);
      check($sformatf("t4_hold%0d_cmd_ready", i), 32'(cmd_ready), 0);
      check($sformatf("t4_hold%0d_busy", i), 32'(busy), 1);
      check($sformatf("t4_hold%0d_psel", i), 32'(psel), 0);
    end
    rsp_ready = 1'b1;
    step();
    check("t4_consumed_valid", 32'(rsp_valid), 0);
    check("t4_not_yet_psel",   32'(psel), 0);
    check("t4_cmd_ready",      32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    check("t4_second_psel",   32'(psel), 1);
    check("t4_second_paddr",  paddr, 32'h20);
    check("t4_second_pwrite", 32'(pwrite), 1);
    check("t4_second_pwdata", pwdata, 32'h0BADF00D);
    pready = 1'b1;
    prdata = 32'h77777777;
    step();
    step();
    check("t4_second_rsp_valid", 32'(rsp_valid), 1);
    check("t4_second_rsp_rdata", rsp_rdata, 0);
    pready = 1'b0;
    step();

    // ---- 5: reset during ACCESS ----
    issue(1'b1, 32'h1C, 32'h11112222);
    step();
    step();
    check("t5_in_access", 32'(penable), 1);
    reset = 1'b1;
    step();
    check("t5_rst_psel",      32'(psel), 0);
    check("t5_rst_penable",   32'(penable), 0);
    check("t5_rst_rsp_valid", 32'(rsp_valid), 0);
    check("t5_rst_busy",      32'(busy), 0);
    check("t5_rst_paddr",     paddr, 0);
    reset = 1'b0;
    step();
    check("t5_no_rsp", 32'(rsp_valid), 0);
    pready = 1'b1;
    prdata = 32'h55AA55AA;
    issue(1'b0, 32'h10, 32'h0);
    check("t5_read_paddr", paddr, 32'h10);
    step();
    step();
    check("t5_read_rsp_valid", 32'(rsp_valid), 1);
    check("t5_read_rsp_rdata", rsp_rdata, 32'h55AA55AA);
    check("t5_read_rsp_err",   32'(rsp_err), 0);
    pready = 1'b0;
    step();

    // ---- 6: pready on the last allowed cycle (dut_b, 4-cycle timeout) ----
    b_prdata    = 32'hFFFFFFFF;
    b_cmd_valid = 1'b1;
    b_cmd_write = 1'b0;
    b_cmd_addr  = 32'h40;
    step();
    b_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t6_acc%0d_penable", i), 32'(b_penable), 1);
      if (i == 3) begin
        b_pready = 1'b1;
        b_prdata = 32'h12345678;
      end
    end
    step();
    check("t6_rsp_valid", 32'(b_rsp_valid), 1);
    check("t6_rsp_err",   32'(b_rsp_err), 0);
    check("t6_rsp_rdata", b_rsp_rdata, 32'h12345678);
    b_pready = 1'b0;
    step();

    // Same block with pready stuck low aborts after four ACCESS cycles.
    b_cmd_valid = 1'b1;
    step();
    b_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t6b_acc%0d_penable", i), 32'(b_penable), 1);
    end
    step();
    check("t6b_penable", 32'(b_penable), 0);
    check("t6b_rsp_err", 32'(b_rsp_err), 1);
    check("t6b_rdata",   b_rsp_rdata, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
